// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel NCO clock-enable generator with configuration lock sequencer
module clk_enable_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      resync,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS-1:0]       sq,
    output logic                      locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          lock_cnt;
    logic [CNT_W-1:0]          lock_cnt_next;
    logic                      locked_next;
    logic [CHANNELS*ACC_W-1:0] inc_q;
    logic                      inc_q_ok;
    logic                      restart;
    logic                      run;

    // inc_q holds no real history on the first edge after reset, so no change is flagged there
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            inc_q    <= '0;
            inc_q_ok <= 1'b0;
        end else begin
            inc_q    <= inc;
            inc_q_ok <= 1'b1;
        end
    end

    assign restart = resync | (inc_q_ok & (inc != inc_q));
    assign run     = locked & ~restart;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
            locked   <= locked_next;
        end
    end

    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = UNLOCKED;
        end else if (state == UNLOCKED && lock_cnt == CNT_LAST) begin
            state_next = LOCKED;
        end
    end

    // Counter parks at CNT_LAST once reached so it never wraps while locked
    always_comb begin
        lock_cnt_next = lock_cnt;
        locked_next   = (state_next == LOCKED);
        if (restart) begin
            lock_cnt_next = '0;
        end else if (state == UNLOCKED && lock_cnt != CNT_LAST) begin
            lock_cnt_next = lock_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             ce_r;
        logic             sq_r;

        assign sum = {1'b0, acc} + {1'b0, inc[i*ACC_W +: ACC_W]};

        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                acc  <= '0;
                ce_r <= 1'b0;
                sq_r <= 1'b0;
            end else if (!run || !ch_en[i]) begin
                acc  <= '0;
                ce_r <= 1'b0;
                sq_r <= 1'b0;
            end else begin
                acc  <= sum[ACC_W-1:0];
                ce_r <= sum[ACC_W];
                sq_r <= sq_r ^ sum[ACC_W];
            end
        end

        assign ce[i] = ce_r;
        assign sq[i] = sq_r;
    end

endmodule
